reg_file_arbiter: RTL and testbench

//  Shares the dual-read/single-write 8-bit register file between two requesters:
//  the decode read port (two operands) and the writeback write port.

---
 rtl/omega8_pkg.sv | 19 +
 rtl/reg_arb_timer.sv | 33 +++
 rtl/reg_file_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_reg_file_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/omega8_pkg.sv
// rtl/omega8_pkg.sv - shared widths, arbiter state encoding and register constants
package omega8_pkg;
  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 8;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } arb_grant_e;
endpackage

// File: rtl/reg_arb_timer.sv
// rtl/reg_arb_timer.sv - saturating up-counter with clear, enable and limit-hit flag
module reg_arb_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_hit
);
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en && (count_q != i_limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_hit = (count_q == i_limit);
endmodule

// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - arbitrates decode reads and writeback writes onto the register file
// Optional watchdog on a missing i_rf_done: REG_FILE_ARB_TIMEOUT_EN
module reg_file_arbiter
  import omega8_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd_req,
  input  logic [REG_IDX_W-1:0] i_rd_addr1,
  input  logic [REG_IDX_W-1:0] i_rd_addr2,
  output logic                 o_rd_valid,
  output logic [DATA_W-1:0]    o_rd_data1,
  output logic [DATA_W-1:0]    o_rd_data2,
  input  logic                 i_wr_req,
  input  logic [REG_IDX_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]    i_wr_data,
  output logic                 o_wr_ack,
  output logic [REG_IDX_W-1:0] o_rf_address1,
  output logic [REG_IDX_W-1:0] o_rf_address2,
  output logic [DATA_W-1:0]    o_rf_data,
  output logic                 o_rf_read,
  output logic                 o_rf_write,
  input  logic                 i_rf_done,
  input  logic [DATA_W-1:0]    i_rf_data1,
  input  logic [DATA_W-1:0]    i_rf_data2,
  output logic                 o_err
);
  arb_state_e           state_q, state_d;
  arb_grant_e           grant_q, grant_d;
  logic [REG_IDX_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic                 rf_read_q, rf_read_d, rf_write_q, rf_write_d;
  logic                 rd_valid_q, rd_valid_d, wr_ack_q, wr_ack_d;
  logic                 starve_clr, starve_inc, starve_hit;
  logic                 wd_hit;

  // Counts arbitration losses of a pending read; hit forces the read through.
  reg_arb_timer #(.W(4)) u_starve (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (starve_clr),
    .i_en    (starve_inc),
    .i_limit (4'(MAX_WAIT)),
    .o_hit   (starve_hit)
  );

`ifdef REG_FILE_ARB_TIMEOUT_EN
  logic err_q, err_d;

  // Count register equals (WAIT cycles - 1), so hit marks the TIMEOUT-th WAIT cycle.
  reg_arb_timer #(.W(8)) u_watchdog (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q != ARB_WAIT),
    .i_en    (state_q == ARB_WAIT),
    .i_limit (8'(TIMEOUT - 1)),
    .o_hit   (wd_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    err_d = err_q;
    if ((state_q == ARB_WAIT) && !i_rf_done && wd_hit) begin
      err_d = 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT);
  assign wd_hit         = 1'b0;
  assign o_err          = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    wdata_d    = wdata_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    rf_read_d  = 1'b0;
    rf_write_d = 1'b0;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    starve_clr = 1'b0;
    starve_inc = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (i_rd_req && (!i_wr_req || starve_hit)) begin
          grant_d    = GNT_RD;
          addr1_d    = i_rd_addr1;
          addr2_d    = i_rd_addr2;
          rf_read_d  = 1'b1;
          starve_clr = 1'b1;
          state_d    = ARB_ISSUE;
        end else if (i_wr_req) begin
          grant_d    = GNT_WR;
          addr1_d    = i_wr_addr;
          wdata_d    = i_wr_data;
          starve_inc = i_rd_req;
          // Index 0 is hardwired: acknowledge without touching the file.
          if (i_wr_addr == REG_ZERO) begin
            wr_ack_d = 1'b1;
            state_d  = ARB_RESP;
          end else begin
            rf_write_d = 1'b1;
            state_d    = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (i_rf_done || wd_hit) begin
          state_d = ARB_RESP;
          if (grant_q == GNT_RD) begin
            rd_valid_d = 1'b1;
            rdata1_d   = i_rf_done ? i_rf_data1 : '0;
            rdata2_d   = i_rf_done ? i_rf_data2 : '0;
          end else begin
            wr_ack_d = 1'b1;
          end
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= GNT_WR;
      addr1_q    <= '0;
      addr2_q    <= '0;
      wdata_q    <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      rf_read_q  <= 1'b0;
      rf_write_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      wdata_q    <= wdata_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      rf_read_q  <= rf_read_d;
      rf_write_q <= rf_write_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  assign o_rf_address1 = addr1_q;
  assign o_rf_address2 = addr2_q;
  assign o_rf_data     = wdata_q;
  assign o_rf_read     = rf_read_q;
  assign o_rf_write    = rf_write_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data1    = rdata1_q;
  assign o_rd_data2    = rdata2_q;
  assign o_wr_ack      = wr_ack_q;
endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb/tb_reg_file_arbiter.sv - randomized self-checking bench with a register-file model
module tb_reg_file_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 15;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rd_req = 1'b0;
  logic [2:0] i_rd_addr1 = '0, i_rd_addr2 = '0;
  logic       o_rd_valid;
  logic [7:0] o_rd_data1, o_rd_data2;
  logic       i_wr_req = 1'b0;
  logic [2:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic       o_wr_ack;
  logic [2:0] o_rf_address1, o_rf_address2;
  logic [7:0] o_rf_data;
  logic       o_rf_read, o_rf_write;
  logic       i_rf_done = 1'b0;
  logic [7:0] i_rf_data1 = '0, i_rf_data2 = '0;
  logic       o_err;

  reg_file_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rd_req(i_rd_req), .i_rd_addr1(i_rd_addr1), .i_rd_addr2(i_rd_addr2),
    .o_rd_valid(o_rd_valid), .o_rd_data1(o_rd_data1), .o_rd_data2(o_rd_data2),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
    .o_rf_address1(o_rf_address1), .o_rf_address2(o_rf_address2), .o_rf_data(o_rf_data),
    .o_rf_read(o_rf_read), .o_rf_write(o_rf_write),
    .i_rf_done(i_rf_done), .i_rf_data1(i_rf_data1), .i_rf_data2(i_rf_data2),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int model_starve = 0;
  logic [7:0] rf_mem[8];
  logic [7:0] exp_mem[8];
  bit rf_mute = 1'b0;
  bit rf_pend = 1'b0;
  logic [2:0] rf_a1 = '0, rf_a2 = '0;
  logic [34:0] all_outs;

  assign all_outs = {o_rd_valid, o_rd_data1, o_rd_data2, o_wr_ack, o_rf_address1, o_rf_address2,
                     o_rf_data, o_rf_read, o_rf_write, o_err};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file: done one cycle after the strobe, unless muted.
  initial forever begin
    @(posedge i_clk);
    #1;
    i_rf_done = 1'b0;
    if (rf_pend) begin
      rf_pend = 1'b0;
      if (!rf_mute) begin
        i_rf_done  = 1'b1;
        i_rf_data1 = rf_mem[rf_a1];
        i_rf_data2 = rf_mem[rf_a2];
      end
    end
    if (o_rf_write) begin
      rf_mem[o_rf_address1] = o_rf_data;
      rf_pend = 1'b1;
    end
    if (o_rf_read) begin
      rf_a1 = o_rf_address1;
      rf_a2 = o_rf_address2;
      rf_pend = 1'b1;
    end
  end

  task automatic access(input bit is_wr, input logic [2:0] a1, input logic [2:0] a2,
                        input logic [7:0] wd, input int budget,
                        output bit got, output int lat, output int strobe_at, output int nstrobe,
                        output logic [7:0] d1, output logic [7:0] d2, output logic after);
    @(negedge i_clk);
    if (is_wr) begin
      i_wr_req = 1'b1; i_wr_addr = a1; i_wr_data = wd;
    end else begin
      i_rd_req = 1'b1; i_rd_addr1 = a1; i_rd_addr2 = a2;
    end
    got = 1'b0; lat = 0; strobe_at = 0; nstrobe = 0; d1 = '0; d2 = '0; after = 1'b0;
    for (int k = 1; k <= budget && !got; k++) begin
      @(negedge i_clk);
      if (o_rf_read || o_rf_write) begin
        nstrobe++;
        if (strobe_at == 0) strobe_at = k;
      end
      if (is_wr ? o_wr_ack : o_rd_valid) begin
        got = 1'b1; lat = k; d1 = o_rd_data1; d2 = o_rd_data2;
      end
    end
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    @(negedge i_clk);
    after = is_wr ? o_wr_ack : o_rd_valid;
  endtask

  initial begin
    bit got;
    int lat, sat, nst, npulse, seen;
    logic [7:0] d1, d2, wd;
    logic [2:0] a1, a2;
    logic after;
    bit is_wr;
    logic [7:0] seq[$];

    for (int i = 0; i < 8; i++) begin
      rf_mem[i]  = 8'($urandom);
      exp_mem[i] = rf_mem[i];
    end
    rf_mem[3] = 8'hA5; exp_mem[3] = 8'hA5;
    rf_mem[5] = 8'h3C; exp_mem[5] = 8'h3C;

    repeat (3) @(negedge i_clk);
    check("reset_outputs", 64'(all_outs), 64'd0);
    i_rst_n = 1'b1;

    // 1: read only
    access(1'b0, 3'd3, 3'd5, 8'h00, 50, got, lat, sat, nst, d1, d2, after);
    model_starve = 0;
    check("rd_got", 64'(got), 64'd1);
    check("rd_strobe_at", 64'(sat), 64'd1);
    check("rd_strobe_cnt", 64'(nst), 64'd1);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_data1", 64'(d1), 64'hA5);
    check("rd_data2", 64'(d2), 64'h3C);
    check("rd_pulse_width", 64'(after), 64'd0);

    // 2: write only
    access(1'b1, 3'd2, 3'd0, 8'h7E, 50, got, lat, sat, nst, d1, d2, after);
    exp_mem[2] = 8'h7E;
    check("wr_strobe_at", 64'(sat), 64'd1);
    check("wr_strobe_cnt", 64'(nst), 64'd1);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_file_content", 64'(rf_mem[2]), 64'h7E);
    check("wr_pulse_width", 64'(after), 64'd0);

    // 4: write to index 0
    access(1'b1, 3'd0, 3'd0, 8'hFF, 50, got, lat, sat, nst, d1, d2, after);
    check("wr0_strobe_cnt", 64'(nst), 64'd0);
    check("wr0_latency", 64'(lat), 64'd1);
    check("wr0_file_untouched", 64'(rf_mem[0]), 64'(exp_mem[0]));

    // randomized single-requester traffic against the shadow register array
    for (int i = 0; i < 12; i++) begin
      is_wr = 1'($urandom_range(0, 1));
      a1 = 3'($urandom_range(0, 7));
      a2 = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      access(is_wr, a1, a2, wd, 50, got, lat, sat, nst, d1, d2, after);
      if (is_wr) begin
        check("rnd_wr_latency", 64'(lat), (a1 == 3'd0) ? 64'd1 : 64'd3);
        check("rnd_wr_strobes", 64'(nst), (a1 == 3'd0) ? 64'd0 : 64'd1);
        if (a1 != 3'd0) exp_mem[a1] = wd;
      end else begin
        model_starve = 0;
        check("rnd_rd_latency", 64'(lat), 64'd3);
        check("rnd_rd_data", 64'({d1, d2}), 64'({exp_mem[a1], exp_mem[a2]}));
      end
    end

    // 3: both requesters held; grant order from the starvation rule
    @(negedge i_clk);
    i_rd_req = 1'b1; i_rd_addr1 = 3'($urandom); i_rd_addr2 = 3'($urandom);
    i_wr_req = 1'b1; i_wr_addr = 3'($urandom); i_wr_data = 8'($urandom);
    npulse = 0;
    for (int c = 0; c < 300 && npulse < 10; c++) begin
      @(negedge i_clk);
      if (o_wr_ack) begin
        seq.push_back("W");
        npulse++;
        if (i_wr_addr != 3'd0) exp_mem[i_wr_addr] = i_wr_data;
        i_wr_addr = 3'($urandom); i_wr_data = 8'($urandom);
      end
      if (o_rd_valid) begin
        seq.push_back("R");
        npulse++;
        check("arb_rd_data", 64'({o_rd_data1, o_rd_data2}),
              64'({exp_mem[i_rd_addr1], exp_mem[i_rd_addr2]}));
        i_rd_addr1 = 3'($urandom); i_rd_addr2 = 3'($urandom);
      end
    end
    i_rd_req = 1'b0; i_wr_req = 1'b0;
    check("arb_pulse_count", 64'(seq.size()), 64'd10);
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
      if (model_starve == MAX_WAIT) begin
        check("arb_grant_order", 64'(seq[i]), 64'("R"));
        model_starve = 0;
      end else begin
        check("arb_grant_order", 64'(seq[i]), 64'("W"));
        model_starve++;
      end
    end
    repeat (2) @(negedge i_clk);

    // 5: missing done
    rf_mute = 1'b1;
`ifdef REG_FILE_ARB_TIMEOUT_EN
    access(1'b0, 3'd1, 3'd2, 8'h00, 60, got, lat, sat, nst, d1, d2, after);
    check("wd_got", 64'(got), 64'd1);
    check("wd_latency", 64'(lat), 64'(TIMEOUT + 2));
    check("wd_data", 64'({d1, d2}), 64'd0);
    check("wd_err", 64'(o_err), 64'd1);
    rf_mute = 1'b0;
    access(1'b0, 3'd3, 3'd5, 8'h00, 50, got, lat, sat, nst, d1, d2, after);
    check("wd_err_sticky", 64'(o_err), 64'd1);
    check("wd_after_data", 64'({d1, d2}), 64'({exp_mem[3], exp_mem[5]}));
    rf_mute = 1'b1;
    @(negedge i_clk);
    i_rd_req = 1'b1; i_rd_addr1 = 3'd6; i_rd_addr2 = 3'd7;
    repeat (3) @(negedge i_clk);
`else
    @(negedge i_clk);
    i_rd_req = 1'b1; i_rd_addr1 = 3'd6; i_rd_addr2 = 3'd7;
    seen = 0;
    repeat (102) begin
      @(negedge i_clk);
      if (o_rd_valid) seen++;
    end
    check("nowd_no_valid", 64'(seen), 64'd0);
    check("nowd_addr_held", 64'({o_rf_address1, o_rf_address2}), 64'({3'd6, 3'd7}));
    check("nowd_err", 64'(o_err), 64'd0);
`endif

    // 6: reset during WAIT
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_wait_outputs", 64'(all_outs), 64'd0);
    i_rd_req = 1'b0;
    rf_mute = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_starve = 0;
    seen = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_rd_valid || o_wr_ack) seen++;
    end
    check("rst_no_pulse", 64'(seen), 64'd0);
    access(1'b0, 3'd2, 3'd3, 8'h00, 50, got, lat, sat, nst, d1, d2, after);
    check("rst_next_latency", 64'(lat), 64'd3);
    check("rst_next_data", 64'({d1, d2}), 64'({exp_mem[2], exp_mem[3]}));
    check("rst_err_clear", 64'(o_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
